// File: rtl/client_tilelink_finish_unit.sv
// Client-side TileLink finish generator: passes grants through, counts multibeat data,
// queues {manager_xact_id, manager_id} and issues finishes. Optional macro: CLIENT_FINISH_BYPASS_EN.
module client_tilelink_finish_unit #(
    parameter int DEPTH = 2,
    parameter int BEATS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_in_grant_valid,
    output logic        io_in_grant_ready,
    input  logic [2:0]  io_in_grant_bits_addr_beat,
    input  logic [1:0]  io_in_grant_bits_client_xact_id,
    input  logic        io_in_grant_bits_manager_xact_id,
    input  logic        io_in_grant_bits_is_builtin_type,
    input  logic [3:0]  io_in_grant_bits_g_type,
    input  logic [63:0] io_in_grant_bits_data,
    input  logic        io_in_grant_bits_manager_id,
    output logic        io_out_grant_valid,
    input  logic        io_out_grant_ready,
    output logic [2:0]  io_out_grant_bits_addr_beat,
    output logic [1:0]  io_out_grant_bits_client_xact_id,
    output logic        io_out_grant_bits_manager_xact_id,
    output logic        io_out_grant_bits_is_builtin_type,
    output logic [3:0]  io_out_grant_bits_g_type,
    output logic [63:0] io_out_grant_bits_data,
    output logic        io_out_grant_bits_manager_id,
    output logic        io_finish_valid,
    input  logic        io_finish_ready,
    output logic        io_finish_bits_manager_xact_id,
    output logic        io_finish_bits_manager_id
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [2:0]    LAST_BEAT = 3'(BEATS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    logic [2:0]    beat_cnt_q, beat_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    mem_q [DEPTH];
    logic [1:0]    mem_d [DEPTH];

    logic needs_fin, multibeat, last, fifo_full, block, fire, push;
    logic fifo_valid, bypass_take, push_wr, pop_fifo;
    logic [1:0] fin_bits;

    assign io_out_grant_bits_addr_beat       = io_in_grant_bits_addr_beat;
    assign io_out_grant_bits_client_xact_id  = io_in_grant_bits_client_xact_id;
    assign io_out_grant_bits_manager_xact_id = io_in_grant_bits_manager_xact_id;
    assign io_out_grant_bits_is_builtin_type = io_in_grant_bits_is_builtin_type;
    assign io_out_grant_bits_g_type          = io_in_grant_bits_g_type;
    assign io_out_grant_bits_data            = io_in_grant_bits_data;
    assign io_out_grant_bits_manager_id      = io_in_grant_bits_manager_id;

    always_comb begin
        needs_fin = !io_in_grant_bits_is_builtin_type;
        multibeat = (io_in_grant_bits_is_builtin_type && io_in_grant_bits_g_type == 4'd5) ||
                    (!io_in_grant_bits_is_builtin_type && io_in_grant_bits_g_type <= 4'd1);
        last      = !multibeat || (beat_cnt_q == LAST_BEAT);
        fifo_full = (count_q == FULL_CNT);
        // Only the beat that would push into a full FIFO is held back.
        block     = needs_fin && last && fifo_full;

        io_in_grant_ready  = reset && io_out_grant_ready && !block;
        io_out_grant_valid = reset && io_in_grant_valid && !block;
        fire = io_in_grant_valid && io_in_grant_ready;
        push = fire && needs_fin && last;

        fifo_valid  = (count_q != '0);
        fin_bits    = fifo_valid ? mem_q[rd_ptr_q] : 2'b00;
        io_finish_valid = fifo_valid;
        bypass_take = 1'b0;
`ifdef CLIENT_FINISH_BYPASS_EN
        if (!fifo_valid && push) begin
            io_finish_valid = 1'b1;
            fin_bits        = {io_in_grant_bits_manager_xact_id, io_in_grant_bits_manager_id};
            bypass_take     = io_finish_ready;
        end
`endif
        io_finish_bits_manager_xact_id = fin_bits[1];
        io_finish_bits_manager_id      = fin_bits[0];

        push_wr  = push && !bypass_take;
        pop_fifo = fifo_valid && io_finish_ready;

        beat_cnt_d = beat_cnt_q;
        if (fire && multibeat) begin
            beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? 3'd0 : beat_cnt_q + 3'd1;
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (push_wr) begin
            mem_d[wr_ptr_q] = {io_in_grant_bits_manager_xact_id, io_in_grant_bits_manager_id};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        rd_ptr_d = pop_fifo ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push_wr && !pop_fifo) begin
            count_d = count_q + CW'(1);
        end else if (!push_wr && pop_fifo) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_cnt_q <= 3'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage carries no reset; the output is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
